// File: rtl/seq_scan_sched_if.sv
// Request/grant/result bundle between the lane capture registers and the
// shared 0101 scan scheduler.
interface seq_scan_sched_if #(
   parameter int W     = 8,
   parameter int CNT_W = 4
);
   logic [3:0]       req;
   logic [4*W-1:0]   data_in;
   logic [3:0]       gnt;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] result_cnt;
   logic [1:0]       result_id;

   modport master (
      output req, data_in,
      input  gnt, busy, done, result_cnt, result_id
   );

   modport slave (
      input  req, data_in,
      output gnt, busy, done, result_cnt, result_id
   );
endinterface

// File: rtl/seq_scan_sched.sv
// Round-robin scheduler sharing one MSB-first overlapping Moore 0101
// detector among four requesters; one word is served every W+2 cycles.
module seq_scan_sched #(
   parameter int W     = 8,
   parameter int CNT_W = 4
) (
   input logic           clk,
   input logic           rst,
   seq_scan_sched_if.slave bus
);
   localparam int BW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
   typedef enum logic [2:0] {S1, S2, S3, S4, S5} det_e;

   state_e           state_q, state_d;
   det_e             det_q, det_d, det_nxt;
   logic [1:0]       rr_q, rr_d;
   logic [1:0]       id_q, id_d;
   logic [3:0]       gnt_q, gnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] match_q, match_d;
   logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
   logic [1:0]       id_out_q, id_out_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             found;
   logic [1:0]       pick;

   function automatic det_e det_step(det_e s, logic b);
      case (s)
         S1:      return b ? S1 : S2;
         S2:      return b ? S3 : S2;
         S3:      return b ? S1 : S4;
         S4:      return b ? S5 : S2;
         S5:      return b ? S1 : S4;
         default: return S1;
      endcase
   endfunction

   assign det_nxt = det_step(det_q, shreg_q[W-1]);

   // First requester at or above the rr pointer, wrapping 3 -> 0.
   always_comb begin : p_pick
      logic [1:0] idx;
      found = 1'b0;
      pick  = rr_q;
      idx   = '0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_q + 2'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // NOTE: every _d gets its hold value first so no path leaves it
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_d   = state_q;
      det_d     = det_q;
      rr_d      = rr_q;
      id_d      = id_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      match_d   = match_q;
      cnt_out_d = cnt_out_q;
      id_out_d  = id_out_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d    = 4'(1) << pick;
               busy_d   = 1'b1;
               shreg_d  = bus.data_in[pick*W +: W];
               id_d     = pick;
               match_d  = '0;
               det_d    = S1;
               bitcnt_d = BW'(W - 1);
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            gnt_d   = '0;
            det_d   = det_nxt;
            shreg_d = shreg_q << 1;
            if (det_nxt == S5 && match_q != '1)
               match_d = match_q + CNT_W'(1);
            bitcnt_d = bitcnt_q - BW'(1);
            if (bitcnt_q == '0) begin
               // Result includes a match landing on the final bit.
               done_d    = 1'b1;
               cnt_out_d = match_d;
               id_out_d  = id_q;
               bitcnt_d  = '0;
               state_d   = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b0;
            busy_d  = 1'b0;
            rr_d    = id_q + 2'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         det_q     <= S1;
         rr_q      <= '0;
         id_q      <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         match_q   <= '0;
         cnt_out_q <= '0;
         id_out_q  <= '0;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         det_q     <= det_d;
         rr_q      <= rr_d;
         id_q      <= id_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         match_q   <= match_d;
         cnt_out_q <= cnt_out_d;
         id_out_q  <= id_out_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.result_cnt = cnt_out_q;
   assign bus.result_id  = id_out_q;
endmodule

// File: doc/seq_scan_sched.md
Name: seq_scan_sched

Overview:
- Round-robin scheduler that shares one serial "0101" pattern-detection engine among 4 requesters.
- Each requester presents a W-bit word. The scheduler grants one requester, latches its word and shifts it MSB-first through an internal overlapping Moore 0101 detector.
- It counts matches and returns the count and the requester id with a one-cycle done pulse.
- It sits between the per-lane capture registers and the match-statistics logic.

Parameters:
- W, 8, word length in bits shifted per grant; legal range 4..32.
- CNT_W, 4, width of the match count; the count saturates at all-ones.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  per-requester request level, bit i = requester i
- data_in  input  4*W  requester i word at bits [i*W+W-1 : i*W]; sampled only on the grant edge
- gnt  output  4  registered one-hot grant, high for exactly one cycle
- busy  output  1  high from the grant edge until the scheduler returns to IDLE
- done  output  1  one-cycle pulse; result_cnt and result_id are valid while done is high
- result_cnt  output  CNT_W  number of 0101 matches found in the granted word
- result_id  output  2  index of the requester whose word produced result_cnt

Behaviour:
- Reset (asynchronous, active-high), all of the following:
  - state = IDLE, rr pointer = 0
  - gnt = 0, busy = 0, done = 0, result_cnt = 0, result_id = 0
  - detector = S1, shift register = 0, bit counter = 0
- Reset asserted mid-word aborts the word. No done is produced and no result is kept.
- Control FSM states: IDLE, SHIFT, DONE.
- IDLE, at edge k with req != 0:
  - Grant the first requester with req set, searching from the rr pointer upward with wrap 3->0.
  - gnt <= one-hot of that requester; busy <= 1; latch its data_in word; id <= index.
  - match count <= 0; detector <= S1; bit counter <= W-1; state <= SHIFT.
- IDLE with req == 0: hold all state; outputs stay low.
- SHIFT:
  - gnt <= 0 at edge k+1.
  - Edges k+1 .. k+W each consume one bit, MSB first: word[W-1] at k+1, word[0] at k+W.
  - The detector advances once per consumed bit.
  - The match count increments (saturating) on every edge where the detector next-state is S5.
- End of word, edge k+W:
  - done <= 1; result_cnt <= final count, including any match on the last bit; result_id <= id.
  - state <= DONE.
- DONE, edge k+W+1: done <= 0; rr pointer <= (id+1) mod 4; state <= IDLE; busy <= 0.
- Throughput and latency:
  - Earliest next grant is edge k+W+2, so one word is served every W+2 cycles.
  - result_cnt and result_id hold their values until the next done.
- Detector: Moore, overlapping. States S1 (none), S2 ("0"), S3 ("01"), S4 ("010"), S5 ("0101").
  - S1: 0->S2, 1->S1
  - S2: 0->S2, 1->S3
  - S3: 0->S4, 1->S1
  - S4: 0->S2, 1->S5
  - S5: 0->S4, 1->S1
- The detector is restarted at S1 for every word; there is no overlap across words.
- Request handling:
  - req is a level, not a pulse. A requester that keeps req high after its grant is served again only after the rr pointer passes it, so fairness is preserved.
  - req changes during SHIFT/DONE are ignored until the scheduler returns to IDLE.
  - data_in changes after the grant edge do not affect the word in flight.
- Arithmetic: with CNT_W=4 and W=32, at most 15 matches are possible, so the count never saturates. Saturation is required only for smaller CNT_W overrides.

Test Plan:
- Reset, then req=4'b0001 with word0=8'b0101_0101 -> gnt=0001 for 1 cycle; done exactly W=8 cycles after the gnt edge; result_cnt=3; result_id=0.
- req=4'b0100 with word2=8'b0010_1011 -> result_cnt=2, result_id=2. Separately, word2=8'h00 -> result_cnt=0. Separately, word2=8'hFF -> result_cnt=0.
- req=4'b1111 held continuously, all words 8'h55 -> grant order 0,1,2,3,0; successive grants 10 cycles apart; result_id sequence 0,1,2,3,0, each with result_cnt=3.
- req=4'b1001 with rr pointer=1 (after serving requester 0) -> requester 3 granted before 0. Changing data_in of the active requester during SHIFT leaves result_cnt unchanged.
- Assert reset 4 cycles into SHIFT -> all outputs 0 immediately with no clock; no done pulse. After release, the same request restarts from requester 0 and produces the correct full count.
- req=0 for 20 cycles after reset -> busy=0, gnt=0, done=0 throughout.
